pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and fetch-control stage directly downstream of the branch unit. Consumes its `PC_SRC`/`B_TAKE` decision and holds the 8-bit PC. Handles:
- boot-time reset-vector load from instruction memory address 0
- interrupt-vector load from address 1
- branch/return redirects, with flush pulses to the front-end pipeline registers
- stalls from the hazard unit

## Interface
Parameters:
- `PC_W`, 8, PC and address width
- `RST_VEC_ADDR`, 8'h00, address of the reset vector
- `INT_VEC_ADDR`, 8'h01, address of the interrupt vector
- `FLUSH_CYCLES`, 2, cycles `flush` stays high per redirect (1..3)

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `PC_SRC` in 2: from branch unit; 00 NORM, 01 FW, 10 DataB, 11 treated as NORM
- `B_TAKE` in 1: from branch unit; redirect request
- `fw_target` in PC_W: forwarded register value, used when `PC_SRC`=FW
- `data_b` in PC_W: data-memory read data (popped return address), used when `PC_SRC`=DataB
- `imem_rdata` in PC_W: instruction-memory read data, used only in vector-load states
- `stall` in 1: hazard-unit freeze of the PC
- `int_req` in 1: level interrupt request
- `imem_addr` out PC_W: instruction-memory address
- `pc` out PC_W: current PC
- `pc_plus1` out PC_W: `pc`+1 mod 256, saved by CALL
- `epc` out PC_W: PC saved on interrupt entry
- `flush` out 1: kill IF/ID and ID/EX contents
- `int_ack` out 1: one-cycle pulse on interrupt acceptance
- `fetch_valid` out 1: high only in RUN with no flush

## Operation
- FSM states: BOOT, VEC_RD, RUN, FLUSH.
- **BOOT:** entered on reset. `imem_addr`=`RST_VEC_ADDR`; `vec_sel`<=RST. Next state VEC_RD.
- **VEC_RD:** `pc` <= `imem_rdata`. Next state RUN. `flush`=1 in both BOOT and VEC_RD.
- **RUN:** `imem_addr`=`pc`. Next-PC priority, highest first:
  1. redirect, i.e. `B_TAKE`=1 and `PC_SRC`∈{01,10}: `pc` <= `fw_target` or `data_b`; `flush`=1 this cycle; go to FLUSH for `FLUSH_CYCLES`-1 further cycles. If `FLUSH_CYCLES`=1, stay in RUN.
  2. `int_req`=1: `epc` <= `pc`; `int_ack` pulse; `imem_addr`=`INT_VEC_ADDR`; go to VEC_RD; `flush`=1.
  3. `stall`=1: `pc` holds.
  4. otherwise `pc` <= `pc`+1, wrapping 8'hFF to 8'h00.
- `B_TAKE`=1 with `PC_SRC`=NORM or 11: no redirect; treated as increment.
- **FLUSH:** `flush`=1; `pc` holds (it already holds the target). A down-counter returns the FSM to RUN. `int_req` and `B_TAKE` are ignored here; `int_req` is level, so it is taken on return to RUN.
- Redirect and `stall` in the same cycle: the redirect wins.
- `int_req` during BOOT or VEC_RD is deferred until RUN.
- All PC arithmetic is modulo 2^PC_W; there is no overflow flag.

## Timing
- Reset values: `pc`=0, `epc`=0, `flush`=1 (state BOOT), `int_ack`=0, `fetch_valid`=0, `imem_addr`=`RST_VEC_ADDR`, `pc_plus1`=1.
- Instruction memory is synchronous-read-compatible: `imem_rdata` is sampled one cycle after the address is presented.
- Boot: the first valid fetch is at cycle 2 after `rst_n` deasserts.
- Redirect: the target appears on `pc` one edge after `B_TAKE`. The first valid fetch of the target follows `FLUSH_CYCLES` cycles after the `B_TAKE` cycle.
- Interrupt: the vector appears on `pc` 2 edges after acceptance.
- `flush`, `fetch_valid`, `int_ack`, and `imem_addr` are decoded from state plus current inputs. `pc` and `epc` are registered.
- Asserting `rst_n` low mid-redirect or mid-vector-load forces BOOT immediately and asynchronously. No partial state survives.

## Structure
- The shared processor package holds:
  - `PC_SRC` encodings (NORM=00, FW=01, DataB=10)
  - FSM state enum
  - vector address constants
- Natural sub-module: `flush_counter`, a loadable down-counter with a zero flag.

## Test plan
- **Boot:** reset with `imem_rdata` at addr 0 = 8'h20 → `flush`=1 for 2 cycles, then `pc`=8'h20, `fetch_valid`=1, and the next cycle `pc`=8'h21.
- **Branch:** in RUN at `pc`=8'h10, `B_TAKE`=1, `PC_SRC`=01, `fw_target`=8'h80 → `pc`=8'h80 next edge; `flush` high exactly 2 cycles; then `pc` increments to 8'h81.
- **Return:** `PC_SRC`=10, `data_b`=8'h33, with `stall`=1 the same cycle → `pc`=8'h33 (redirect beats stall).
- **Interrupt:** `int_req` at `pc`=8'h45 → `epc`=8'h45; `int_ack` 1 cycle; `pc` = value at addr 1 (8'h90) after 2 edges. A second `int_req` arriving during FLUSH is taken only after the return to RUN.
- **Wrap:** `pc`=8'hFF with no stall → `pc`=8'h00 and `pc_plus1`=8'h01. `B_TAKE`=1 with `PC_SRC`=11 → plain increment with no flush.
- **Mid-flush reset:** `rst_n` low during FLUSH → BOOT immediately, `pc`=0, vector reloaded.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared processor definitions for the PC/fetch-control stage: PC source
// encodings, vector addresses, FSM state and vector-select enums.
package pc_fetch_unit_pkg;

  localparam int PC_W_DEF = 8;

  localparam logic [1:0] PC_SRC_NORM  = 2'b00;
  localparam logic [1:0] PC_SRC_FW    = 2'b01;
  localparam logic [1:0] PC_SRC_DATAB = 2'b10;

  localparam logic [7:0] RST_VEC_ADDR_DEF = 8'h00;
  localparam logic [7:0] INT_VEC_ADDR_DEF = 8'h01;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_VEC_RD = 2'd1,
    ST_RUN    = 2'd2,
    ST_FLUSH  = 2'd3
  } fetch_state_t;

  typedef enum logic {
    VEC_RST = 1'b0,
    VEC_INT = 1'b1
  } vec_sel_t;

  // Encoding 11 is deliberately not a redirect; it falls through to NORM.
  function automatic logic is_redirect(input logic b_take, input logic [1:0] pc_src);
    return b_take && ((pc_src == PC_SRC_FW) || (pc_src == PC_SRC_DATAB));
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Branch-unit decision, hazard/interrupt inputs, instruction-memory port and
// PC/flush outputs of the fetch-control stage, bundled as one interface.
interface pc_fetch_unit_if
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic [1:0]      PC_SRC;
  logic            B_TAKE;
  logic [PC_W-1:0] fw_target;
  logic [PC_W-1:0] data_b;
  logic [PC_W-1:0] imem_rdata;
  logic            stall;
  logic            int_req;
  logic [PC_W-1:0] imem_addr;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] epc;
  logic            flush;
  logic            int_ack;
  logic            fetch_valid;

  modport master (
    output PC_SRC, B_TAKE, fw_target, data_b, imem_rdata, stall, int_req,
    input  imem_addr, pc, pc_plus1, epc, flush, int_ack, fetch_valid
  );

  modport slave (
    input  PC_SRC, B_TAKE, fw_target, data_b, imem_rdata, stall, int_req,
    output imem_addr, pc, pc_plus1, epc, flush, int_ack, fetch_valid
  );
endinterface

// File: rtl/pc_fetch_unit_flush_counter.sv
// Loadable down-counter with zero flag; times the extra flush cycles after a
// redirect. Load has priority over decrement; no backpressure.
module pc_fetch_unit_flush_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch-control FSM: vector loads, redirects with flush, stalls.
// pc/epc registered (target visible one edge after B_TAKE); flush/ack/addr decoded combinationally.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int              PC_W         = PC_W_DEF,
  parameter logic [PC_W-1:0] RST_VEC_ADDR = PC_W'(RST_VEC_ADDR_DEF),
  parameter logic [PC_W-1:0] INT_VEC_ADDR = PC_W'(INT_VEC_ADDR_DEF),
  parameter int              FLUSH_CYCLES = 2
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_unit_if.slave bus
);

  localparam int         CNT_W       = 2;
  localparam int         FLUSH_EXTRA = (FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_EXTRA);

  fetch_state_t    state, state_nxt;
  vec_sel_t        vec_sel, vec_sel_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [PC_W-1:0] epc, epc_nxt;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            redirect;

  pc_fetch_unit_flush_counter #(.W(CNT_W)) u_flush_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (FLUSH_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign redirect = is_redirect(bus.B_TAKE, bus.PC_SRC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BOOT;
      vec_sel <= VEC_RST;
      pc      <= '0;
      epc     <= '0;
    end else begin
      state   <= state_nxt;
      vec_sel <= vec_sel_nxt;
      pc      <= pc_nxt;
      epc     <= epc_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    vec_sel_nxt     = vec_sel;
    pc_nxt          = pc;
    epc_nxt         = epc;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    bus.imem_addr   = pc;
    bus.flush       = 1'b0;
    bus.int_ack     = 1'b0;
    bus.fetch_valid = 1'b0;

    unique case (state)
      ST_BOOT: begin
        bus.imem_addr = RST_VEC_ADDR;
        bus.flush     = 1'b1;
        vec_sel_nxt   = VEC_RST;
        state_nxt     = ST_VEC_RD;
      end
      // Address is held so a synchronous-read memory still returns the vector.
      ST_VEC_RD: begin
        bus.imem_addr = (vec_sel == VEC_RST) ? RST_VEC_ADDR : INT_VEC_ADDR;
        bus.flush     = 1'b1;
        pc_nxt        = bus.imem_rdata;
        state_nxt     = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_nxt    = (bus.PC_SRC == PC_SRC_FW) ? bus.fw_target : bus.data_b;
          bus.flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            cnt_load  = 1'b1;
            state_nxt = ST_FLUSH;
          end
        end else if (bus.int_req) begin
          epc_nxt       = pc;
          bus.int_ack   = 1'b1;
          bus.imem_addr = INT_VEC_ADDR;
          bus.flush     = 1'b1;
          vec_sel_nxt   = VEC_INT;
          state_nxt     = ST_VEC_RD;
        end else begin
          bus.fetch_valid = 1'b1;
          if (!bus.stall) begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        bus.flush = 1'b1;
        if (cnt_zero) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign bus.pc       = pc;
  assign bus.epc      = epc;
  assign bus.pc_plus1 = pc + PC_W'(1);

endmodule
